// File: rtl/car_drive_ctrl.sv
// Driving controller: power-up sequencing, manual drive and semi-automatic fork/turn handling.
// Optional odometer output is built when CAR_ODOMETER_EN is defined.
module car_drive_ctrl #(
    parameter int POWER_ON_CYCLES   = 100_000_000,
    parameter int TURN_CYCLES       = 90_000_000,
    parameter int CLEAR_CYCLES      = 30_000_000,
    parameter int FLASH_HALF_CYCLES = 50_000_000,
    parameter int CNT_W             = 32
`ifdef CAR_ODOMETER_EN
    ,
    parameter int ODO_TICK_CYCLES   = 100_000_000
`endif
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power_on_signal,
    input  logic       power_off_signal,
    input  logic       manual_driving_signal,
    input  logic       semi_manual_driving_signal,
    input  logic       throttle_signal,
    input  logic       clutch_signal,
    input  logic       brake_signal,
    input  logic       reverse_signal,
    input  logic       turn_left_signal,
    input  logic       turn_right_signal,
    input  logic       move_forward_signal,
    input  logic       place_barrier_signal,
    input  logic       destroy_barrier_signal,
    input  logic [3:0] detector,
    output logic [7:0] cmd_out,
    output logic [3:0] state_out,
    output logic       left_turn_led,
    output logic       right_turn_led,
    output logic       reverse_led,
    output logic       fault
`ifdef CAR_ODOMETER_EN
    ,
    output logic [15:0] odometer
`endif
);

    // state          | meaning
    // S_POWER_OFF    | waiting for a long power_on hold
    // S_POWER_ON     | powered, waiting for mode select
    // S_NOT_STARTING | manual, engine idle
    // S_STARTING     | manual, clutch engaged / starting
    // S_MOVING       | manual, driving
    // S_SA_MOVING    | semi-auto, driving forward until a fork
    // S_SA_WAITING   | semi-auto, at a fork, waiting for a decision
    // S_SA_TURNING   | semi-auto, timed turn in latched direction
    // S_SA_CLEARING  | semi-auto, timed forward with fork masked
    typedef enum logic [3:0] {
        S_POWER_OFF    = 4'd0,
        S_POWER_ON     = 4'd1,
        S_NOT_STARTING = 4'd2,
        S_STARTING     = 4'd3,
        S_MOVING       = 4'd4,
        S_SA_MOVING    = 4'd5,
        S_SA_WAITING   = 4'd6,
        S_SA_TURNING   = 4'd7,
        S_SA_CLEARING  = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] L_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_PWR_LAST   = CNT_W'(POWER_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_FLASH_LAST = CNT_W'(FLASH_HALF_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_pwr_cnt;
    logic [CNT_W-1:0] r_tmr;
    logic [CNT_W-1:0] r_flash_cnt;
    logic             r_flash;
    logic             r_rev_prev;
    logic             r_dir;
    logic             r_fault;
    logic [7:0]       r_cmd;

    logic             w_fork;
    logic             w_rev_edge;
    logic             w_pwr_done;
    logic             w_fault;
    logic             w_dir_load;
    logic [7:0]       w_cmd;
    logic [2:0]       w_tbc;
    logic             w_unused_back;

    assign w_fork        = detector[3] | ~detector[1] | ~detector[0];
    assign w_rev_edge    = reverse_signal ^ r_rev_prev;
    assign w_pwr_done    = power_on_signal && (r_pwr_cnt == L_PWR_LAST);
    assign w_tbc         = {throttle_signal, brake_signal, clutch_signal};
    assign w_unused_back = detector[2];

    always_comb begin
        w_next     = r_state;
        w_fault    = 1'b0;
        w_dir_load = 1'b0;
        case (r_state)
            S_POWER_OFF: begin
                if (w_pwr_done) w_next = S_POWER_ON;
            end
            S_POWER_ON: begin
                if (manual_driving_signal)           w_next = S_NOT_STARTING;
                else if (semi_manual_driving_signal) w_next = S_SA_MOVING;
            end
            S_NOT_STARTING: begin
                if (w_tbc == 3'b101)      w_next = S_STARTING;
                else if (w_tbc == 3'b100) w_next = S_POWER_OFF;
            end
            S_STARTING: begin
                if (brake_signal)         w_next = S_NOT_STARTING;
                else if (w_tbc == 3'b100) w_next = S_MOVING;
            end
            S_MOVING: begin
                // changing gear without the clutch stalls the engine
                if (w_rev_edge && !clutch_signal) begin
                    w_next  = S_POWER_OFF;
                    w_fault = 1'b1;
                end else if (brake_signal) begin
                    w_next = S_NOT_STARTING;
                end else if (clutch_signal || !throttle_signal) begin
                    w_next = S_STARTING;
                end
            end
            S_SA_MOVING: begin
                if (w_fork) w_next = S_SA_WAITING;
            end
            S_SA_WAITING: begin
                if (move_forward_signal) begin
                    w_next = S_SA_CLEARING;
                end else if (turn_left_signal ^ turn_right_signal) begin
                    w_next     = S_SA_TURNING;
                    w_dir_load = 1'b1;
                end
            end
            S_SA_TURNING: begin
                if (r_tmr == L_TURN_LAST) w_next = S_SA_CLEARING;
            end
            S_SA_CLEARING: begin
                if (r_tmr == L_CLEAR_LAST) w_next = S_SA_MOVING;
            end
            default: w_next = S_POWER_OFF;
        endcase
        if (power_off_signal && (r_state != S_POWER_OFF)) begin
            w_next     = S_POWER_OFF;
            w_fault    = 1'b0;
            w_dir_load = 1'b0;
        end
    end

    always_comb begin
        w_cmd = 8'h80;
        case (r_state)
            S_MOVING:      w_cmd[5:0] = {destroy_barrier_signal, place_barrier_signal,
                                         turn_right_signal, turn_left_signal,
                                         reverse_signal, ~reverse_signal};
            S_SA_MOVING,
            S_SA_CLEARING: w_cmd[0] = 1'b1;
            S_SA_TURNING:  w_cmd[3:2] = r_dir ? 2'b10 : 2'b01;
            default:       w_cmd = 8'h80;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_POWER_OFF;
            r_rev_prev <= 1'b0;
            r_dir      <= 1'b0;
            r_fault    <= 1'b0;
            r_cmd      <= 8'h80;
        end else begin
            r_state    <= w_next;
            r_rev_prev <= reverse_signal;
            r_fault    <= w_fault;
            r_cmd      <= w_cmd;
            if (w_dir_load) r_dir <= turn_right_signal;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_pwr_cnt <= '0;
        end else if ((r_state == S_POWER_OFF) && power_on_signal && !w_pwr_done) begin
            r_pwr_cnt <= r_pwr_cnt + L_ONE;
        end else begin
            r_pwr_cnt <= '0;
        end
    end

    // shared by the turn and clear phases; restarts on every state change
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_tmr <= '0;
        end else if (w_next != r_state) begin
            r_tmr <= '0;
        end else if ((r_state == S_SA_TURNING) || (r_state == S_SA_CLEARING)) begin
            r_tmr <= r_tmr + L_ONE;
        end else begin
            r_tmr <= '0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_flash_cnt <= '0;
            r_flash     <= 1'b0;
        end else if (r_flash_cnt == L_FLASH_LAST) begin
            r_flash_cnt <= '0;
            r_flash     <= ~r_flash;
        end else begin
            r_flash_cnt <= r_flash_cnt + L_ONE;
        end
    end

    always_comb begin
        left_turn_led  = 1'b0;
        right_turn_led = 1'b0;
        reverse_led    = 1'b0;
        case (r_state)
            S_NOT_STARTING: begin
                left_turn_led  = 1'b1;
                right_turn_led = 1'b1;
            end
            S_STARTING: reverse_led = reverse_signal;
            S_MOVING: begin
                reverse_led = reverse_signal;
                if (turn_left_signal ^ turn_right_signal) begin
                    left_turn_led  = turn_left_signal & r_flash;
                    right_turn_led = turn_right_signal & r_flash;
                end
            end
            S_SA_WAITING: begin
                left_turn_led  = r_flash;
                right_turn_led = r_flash;
                reverse_led    = r_flash;
            end
            S_SA_TURNING: begin
                left_turn_led  = ~r_dir & r_flash;
                right_turn_led = r_dir & r_flash;
            end
            default: ;
        endcase
    end

    assign cmd_out   = r_cmd;
    assign state_out = r_state;
    assign fault     = r_fault;

`ifdef CAR_ODOMETER_EN
    localparam logic [CNT_W-1:0] L_ODO_LAST = CNT_W'(ODO_TICK_CYCLES - 1);

    logic [CNT_W-1:0] r_odo_cnt;
    logic [15:0]      r_odo;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_odo_cnt <= '0;
            r_odo     <= '0;
        end else if (r_cmd[0] || r_cmd[1]) begin
            if (r_odo_cnt == L_ODO_LAST) begin
                r_odo_cnt <= '0;
                if (r_odo != 16'hFFFF) r_odo <= r_odo + 16'd1;
            end else begin
                r_odo_cnt <= r_odo_cnt + L_ONE;
            end
        end
    end

    assign odometer = r_odo;
`endif

endmodule
